core_axi_io: RTL and testbench

// - AXI4-Lite master sequencer for the core's IN/OUT instructions; parametrised successor of the core's inline UART polling logic.
// - Polls a status register, then moves one RX or TX datum.
// - Drives a STALL-style busy toward the core FSM and returns read data and error status.
// - Sits between core_top (MEMORY stage) and the AXI UART Lite slave.

---
 rtl/core_axi_io.sv | 236 +++++++++++++++++++++++
 tb/tb_core_axi_io.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_axi_io.sv
// core_axi_io: AXI4-Lite master sequencer for the core's IN/OUT instructions.
// Polls the UART status register until the RX/TX condition holds, then moves
// one datum. Optional poll timeout is enabled by defining IO_TIMEOUT_EN.
module core_axi_io #(
  parameter int unsigned       ADDR_W      = 4,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       IO_BYTES    = 1,
  parameter logic [ADDR_W-1:0] RX_OFFSET   = ADDR_W'(4'h0),
  parameter logic [ADDR_W-1:0] TX_OFFSET   = ADDR_W'(4'h4),
  parameter logic [ADDR_W-1:0] STAT_OFFSET = ADDR_W'(4'h8),
  parameter int unsigned       RX_VLD_BIT  = 0,
  parameter int unsigned       TX_FULL_BIT = 3,
  parameter int unsigned       POLL_LIMIT  = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [8*IO_BYTES-1:0] REQ_WDATA,
  output logic                  BUSY,
  output logic                  RSP_VALID,
  output logic [8*IO_BYTES-1:0] RSP_RDATA,
  output logic [1:0]            RSP_ERR,
  output logic [ADDR_W-1:0]     ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_W-1:0]     RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY
);

  localparam int unsigned IO_W   = 8 * IO_BYTES;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [STRB_W-1:0] IO_STRB = STRB_W'((1 << IO_BYTES) - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] RD_AR   = 3'd3;
  localparam logic [2:0] RD_R    = 3'd4;
  localparam logic [2:0] WR_AW_W = 3'd5;
  localparam logic [2:0] WR_B    = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  logic [2:0]          state_q, state_nxt;
  logic                write_q, write_nxt;
  logic [IO_W-1:0]     datum_q, datum_nxt;
  logic                aw_done_q, aw_done_nxt;
  logic                w_done_q, w_done_nxt;

  logic                req_ready_nxt, busy_nxt, rsp_valid_nxt;
  logic [IO_W-1:0]     rsp_rdata_nxt;
  logic [1:0]          rsp_err_nxt;
  logic [ADDR_W-1:0]   araddr_nxt, awaddr_nxt;
  logic                arvalid_nxt, rready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [STRB_W-1:0]   wstrb_nxt;

  logic                unused_sig;

`ifdef IO_TIMEOUT_EN
  logic [15:0]         poll_q, poll_nxt;
  assign unused_sig = ^RDATA;
`else
  assign unused_sig = ^{RDATA, POLL_LIMIT};
`endif

  // Next-state, transfer bookkeeping and next values of all registered outputs
  always_comb begin
    state_nxt     = state_q;
    write_nxt     = write_q;
    datum_nxt     = datum_q;
    aw_done_nxt   = aw_done_q;
    w_done_nxt    = w_done_q;
    rsp_rdata_nxt = RSP_RDATA;
    rsp_err_nxt   = RSP_ERR;
    araddr_nxt    = ARADDR;
    awaddr_nxt    = AWADDR;
    wdata_nxt     = WDATA;
    wstrb_nxt     = WSTRB;
`ifdef IO_TIMEOUT_EN
    poll_nxt      = poll_q;
`endif

    case (state_q)
      IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          write_nxt   = REQ_WRITE;
          datum_nxt   = REQ_WDATA;
          rsp_err_nxt = 2'b00;
`ifdef IO_TIMEOUT_EN
          poll_nxt    = 16'd0;
`endif
          state_nxt   = ST_AR;
        end
      end
      ST_AR: begin
        if (ARVALID && ARREADY) state_nxt = ST_R;
      end
      ST_R: begin
        if (RVALID && RREADY) begin
          if (RRESP != 2'b00) begin
            rsp_err_nxt[0] = 1'b1;
            state_nxt      = DONE;
          end else if (!write_q && RDATA[RX_VLD_BIT]) begin
            state_nxt = RD_AR;
          end else if (write_q && !RDATA[TX_FULL_BIT]) begin
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            awaddr_nxt  = TX_OFFSET;
            wdata_nxt   = DATA_W'(datum_q);
            wstrb_nxt   = IO_STRB;
            state_nxt   = WR_AW_W;
          end else begin
`ifdef IO_TIMEOUT_EN
            // This poll was the last one allowed: give up without moving data
            if (32'(poll_q) + 32'd1 >= POLL_LIMIT) begin
              rsp_err_nxt[1] = 1'b1;
              state_nxt      = DONE;
            end else begin
              poll_nxt  = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
              state_nxt = ST_AR;
            end
`else
            state_nxt = ST_AR;
`endif
          end
        end
      end
      RD_AR: begin
        if (ARVALID && ARREADY) state_nxt = RD_R;
      end
      RD_R: begin
        if (RVALID && RREADY) begin
          rsp_rdata_nxt  = RDATA[IO_W-1:0];
          rsp_err_nxt[0] = |RRESP;
          state_nxt      = DONE;
        end
      end
      WR_AW_W: begin
        if (AWVALID && AWREADY) aw_done_nxt = 1'b1;
        if (WVALID && WREADY)   w_done_nxt  = 1'b1;
        if (aw_done_nxt && w_done_nxt) state_nxt = WR_B;
      end
      WR_B: begin
        if (BVALID && BREADY) begin
          rsp_err_nxt[0] = |BRESP;
          state_nxt      = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Channel controls follow the state being entered; addresses hold while VALID
    if (state_nxt == ST_AR)      araddr_nxt = STAT_OFFSET;
    else if (state_nxt == RD_AR) araddr_nxt = RX_OFFSET;

    arvalid_nxt   = (state_nxt == ST_AR) || (state_nxt == RD_AR);
    rready_nxt    = (state_nxt == ST_R) || (state_nxt == RD_R);
    awvalid_nxt   = (state_nxt == WR_AW_W) && !aw_done_nxt;
    wvalid_nxt    = (state_nxt == WR_AW_W) && !w_done_nxt;
    bready_nxt    = (state_nxt == WR_B);
    req_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
    rsp_valid_nxt = (state_nxt == DONE);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      datum_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      REQ_READY <= 1'b1;
      BUSY      <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 2'b00;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
`ifdef IO_TIMEOUT_EN
      poll_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_nxt;
      write_q   <= write_nxt;
      datum_q   <= datum_nxt;
      aw_done_q <= aw_done_nxt;
      w_done_q  <= w_done_nxt;
      REQ_READY <= req_ready_nxt;
      BUSY      <= busy_nxt;
      RSP_VALID <= rsp_valid_nxt;
      RSP_RDATA <= rsp_rdata_nxt;
      RSP_ERR   <= rsp_err_nxt;
      ARADDR    <= araddr_nxt;
      ARVALID   <= arvalid_nxt;
      RREADY    <= rready_nxt;
      AWADDR    <= awaddr_nxt;
      AWVALID   <= awvalid_nxt;
      WDATA     <= wdata_nxt;
      WSTRB     <= wstrb_nxt;
      WVALID    <= wvalid_nxt;
      BREADY    <= bready_nxt;
`ifdef IO_TIMEOUT_EN
      poll_q    <= poll_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_core_axi_io.sv
// tb_core_axi_io: reactive AXI4-Lite UART slave plus a transaction-level
// reference model (polls, error, data, latency) for core_axi_io.
module tb_core_axi_io;

  localparam int unsigned LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, REQ_READY, REQ_WRITE;
  logic [7:0]  REQ_WDATA;
  logic        BUSY, RSP_VALID;
  logic [7:0]  RSP_RDATA;
  logic [1:0]  RSP_ERR;
  logic [3:0]  ARADDR, AWADDR;
  logic        ARVALID, RREADY, AWVALID, WVALID, BREADY;
  logic        ARREADY = 1'b1;
  logic        WREADY  = 1'b1;
  logic        AWREADY = 1'b1;
  logic        RVALID  = 1'b0;
  logic        BVALID  = 1'b0;
  logic [31:0] RDATA   = 32'd0;
  logic [1:0]  RRESP   = 2'b00;
  logic [1:0]  BRESP   = 2'b00;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;

  always #5 CLK = ~CLK;

  core_axi_io #(
    .ADDR_W(4), .DATA_W(32), .IO_BYTES(1),
    .RX_OFFSET(4'h0), .TX_OFFSET(4'h4), .STAT_OFFSET(4'h8),
    .RX_VLD_BIT(0), .TX_FULL_BIT(3), .POLL_LIMIT(LIMIT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA),
    .BUSY(BUSY), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  // Slave configuration
  logic [31:0] stat_q[$];
  logic [31:0] stat_dflt = 32'd0;
  logic [1:0]  stat_resp = 2'b00;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rx_word   = 32'd0;
  int          aw_delay  = 0;

  // Slave bookkeeping and observation counters
  logic [3:0]  ar_pend[$];
  bit          r_taken, b_taken, aw_seen, w_seen, b_armed, b_pend;
  int          aw_wait;
  int          n_stat, n_rx, n_aw, n_w, awv_cycles, wv_cycles, b_early;
  logic [3:0]  last_awaddr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model_rdata = 8'h00;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe handshakes at the active edge
  always @(posedge CLK) begin
    if (RST) begin
      ar_pend.delete();
      r_taken = 0; b_taken = 0; aw_seen = 0; w_seen = 0; b_armed = 0; b_pend = 0;
      aw_wait = 0;
    end else begin
      if (ARVALID && ARREADY) begin
        ar_pend.push_back(ARADDR);
        if (ARADDR == 4'h8) n_stat++;
        else if (ARADDR == 4'h0) n_rx++;
      end
      if (RVALID && RREADY) r_taken = 1;
      if (BREADY && !(aw_seen && w_seen)) b_early++;
      if (AWVALID) awv_cycles++;
      if (WVALID) wv_cycles++;
      if (AWVALID && !AWREADY) aw_wait++;
      if (AWVALID && AWREADY) begin
        aw_seen = 1; n_aw++; last_awaddr = AWADDR; aw_wait = 0;
      end
      if (WVALID && WREADY) begin
        w_seen = 1; n_w++; last_wdata = WDATA; last_wstrb = WSTRB;
      end
      if (BVALID && BREADY) begin
        b_taken = 1; aw_seen = 0; w_seen = 0; b_armed = 0;
      end
      if (!b_armed && aw_seen && w_seen) begin
        b_pend = 1; b_armed = 1;
      end
    end
  end

  // Drive slave responses away from the active edge
  always @(negedge CLK) begin
    logic [3:0] a;
    if (RST) begin
      RVALID = 1'b0; BVALID = 1'b0; RDATA = 32'd0; RRESP = 2'b00; BRESP = 2'b00;
    end else begin
      if (r_taken) begin RVALID = 1'b0; r_taken = 0; end
      if (ar_pend.size() != 0) begin
        a = ar_pend.pop_front();
        RVALID = 1'b1;
        if (a == 4'h8) begin
          RDATA = (stat_q.size() != 0) ? stat_q.pop_front() : stat_dflt;
          RRESP = stat_resp;
        end else begin
          RDATA = rx_word;
          RRESP = 2'b00;
        end
      end
      if (b_taken) begin BVALID = 1'b0; b_taken = 0; end
      if (b_pend) begin BVALID = 1'b1; BRESP = bresp_cfg; b_pend = 0; end
    end
    AWREADY = (aw_delay == 0) ? 1'b1 : (AWVALID && (aw_wait >= aw_delay - 1));
  end

  // One IN/OUT request checked against the transaction-level model
  task automatic do_req(input bit wr, input logic [7:0] d, input string tag);
    logic [31:0] sq[$];
    logic [31:0] s;
    int          polls = 0;
    bit          xfer = 0;
    logic [1:0]  e = 2'b00;
    int          lat, n, aw_cyc;
    sq = stat_q;
    for (int i = 0; i < 64; i++) begin
      s = (sq.size() != 0) ? sq.pop_front() : stat_dflt;
      polls++;
      if (stat_resp != 2'b00) begin e = 2'b01; break; end
      if (!wr && s[0]) begin xfer = 1; model_rdata = rx_word[7:0]; break; end
      if (wr && !s[3]) begin xfer = 1; e = {1'b0, |bresp_cfg}; break; end
`ifdef IO_TIMEOUT_EN
      if (polls >= int'(LIMIT)) begin e = 2'b10; break; end
`endif
    end
    aw_cyc = (aw_delay > 1) ? aw_delay : 1;
    lat = 2 * polls + 1 + (xfer ? (wr ? aw_cyc + 1 : 2) : 0);

    @(negedge CLK);
    n_stat = 0; n_rx = 0; n_aw = 0; n_w = 0; awv_cycles = 0; wv_cycles = 0; b_early = 0;
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_WDATA = d;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    n = 1;
    check_eq({tag, "_busy"}, 64'({BUSY, REQ_READY}), 64'(2'b10));
    while (!RSP_VALID && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'(lat));
    check_eq({tag, "_err"}, 64'(RSP_ERR), 64'(e));
    check_eq({tag, "_rdata"}, 64'(RSP_RDATA), 64'(model_rdata));
    check_eq({tag, "_polls"}, 64'(n_stat), 64'(polls));
    check_eq({tag, "_rxrd"}, 64'(n_rx), 64'(!wr && xfer));
    check_eq({tag, "_aw"}, 64'({n_aw[3:0], n_w[3:0]}), (wr && xfer) ? 64'(8'h11) : 64'(8'h00));
    if (wr && xfer) begin
      check_eq({tag, "_awaddr"}, 64'(last_awaddr), 64'(4'h4));
      check_eq({tag, "_wdata"}, 64'(last_wdata), 64'({24'd0, d}));
      check_eq({tag, "_wstrb"}, 64'(last_wstrb), 64'(4'b0001));
      check_eq({tag, "_awv_cyc"}, 64'(awv_cycles), 64'(aw_cyc));
      check_eq({tag, "_wv_cyc"}, 64'(wv_cycles), 64'(1));
      check_eq({tag, "_b_order"}, 64'(b_early), 64'(0));
    end
    @(negedge CLK);
    check_eq({tag, "_after"}, 64'({RSP_VALID, BUSY, REQ_READY}), 64'(3'b001));
    stat_q.delete();
  endtask

  task automatic set_cfg(input logic [31:0] dflt, input logic [1:0] sresp,
                         input logic [1:0] bresp, input logic [31:0] rx, input int awd);
    stat_dflt = dflt; stat_resp = sresp; bresp_cfg = bresp; rx_word = rx; aw_delay = awd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          k;
    bit          wr;
    int          nb;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_WDATA = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_valids", 64'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 64'(0));
    check_eq("rst_addr", 64'({ARADDR, AWADDR, WSTRB}), 64'(0));
    check_eq("rst_wdata", 64'(WDATA), 64'(0));
    check_eq("rst_rsp", 64'({BUSY, RSP_VALID, RSP_RDATA, RSP_ERR}), 64'(0));
    check_eq("rst_ready", 64'(REQ_READY), 64'(1));
    RST = 1'b0;

    set_cfg(32'h01, 2'b00, 2'b00, 32'h41, 0);
    do_req(1'b0, 8'h00, "in_basic");

    set_cfg(32'h00, 2'b00, 2'b00, 32'h0, 0);
    stat_q = '{32'h08, 32'h08, 32'h08};
    do_req(1'b1, 8'h5A, "out_poll");

    set_cfg(32'h00, 2'b00, 2'b00, 32'h0, 3);
    do_req(1'b1, 8'hC3, "out_awdly");

    set_cfg(32'h00, 2'b00, 2'b10, 32'h0, 0);
    do_req(1'b1, 8'h11, "out_bresp");

    set_cfg(32'h01, 2'b10, 2'b00, 32'h77, 0);
    do_req(1'b0, 8'h00, "in_slverr");

`ifdef IO_TIMEOUT_EN
    set_cfg(32'h00, 2'b00, 2'b00, 32'h99, 0);
    do_req(1'b0, 8'h00, "in_timeout");
`endif

    // Reset while both write VALIDs are pending
    set_cfg(32'h00, 2'b00, 2'b00, 32'h0, 10);
    WREADY = 1'b0;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_WDATA = 8'hA5;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    k = 0;
    while (!(AWVALID && WVALID) && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check_eq("rst_mid_pre", 64'({AWVALID, WVALID}), 64'(2'b11));
    RST = 1'b1;
    @(negedge CLK);
    check_eq("rst_mid_valids", 64'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 64'(0));
    check_eq("rst_mid_busy", 64'({BUSY, REQ_READY, RSP_VALID}), 64'(3'b010));
    RST = 1'b0;
    WREADY = 1'b1;
    model_rdata = 8'h00;
    set_cfg(32'h01, 2'b00, 2'b00, 32'h1234_5666, 0);
    do_req(1'b0, 8'h00, "in_recover");

    // Randomised requests
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      nb = $urandom_range(0, 5);
      stat_q.delete();
      for (int j = 0; j < nb; j++)
        stat_q.push_back(wr ? ($urandom | 32'h8) : ($urandom & ~32'h1));
      set_cfg(wr ? ($urandom & ~32'h8) : ($urandom | 32'h1),
              ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              $urandom, $urandom_range(0, 3));
      do_req(wr, 8'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
